// File: rtl/nibble_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nibble_add_arbiter
// Purpose  : Shares one OP_W-bit adder between two requesters (A and B).
//            A small IDLE -> EXEC -> OUT controller latches the winner's
//            operands, registers the sum one cycle later and holds the
//            result until the consumer accepts it. Simultaneous requests
//            are resolved round-robin.
//
// Ports    :
//   clk        in   1       single clock, rising edge
//   rst_n      in   1       asynchronous active-low reset
//   req_a      in   1       requester A wants an add
//   a_op0/1    in   OP_W    requester A operands
//   req_b      in   1       requester B wants an add
//   b_op0/1    in   OP_W    requester B operands
//   res_ready  in   1       consumer accepts the result (only looked at in OUT)
//   gnt_a      out  1       one-cycle grant pulse to A (EXEC cycle)
//   gnt_b      out  1       one-cycle grant pulse to B (EXEC cycle)
//   res_valid  out  1       result held valid (OUT state)
//   res_id     out  1       winner of the current result, 0 = A, 1 = B
//   res_sum    out  OP_W+1  registered sum, carry in MSB
//   busy       out  1       controller is not IDLE
//   done_cnt   out  8       completed transactions, wraps modulo 256
//
// Options  : NIBBLE_ADD_SAT_EN - when defined, sums above 2^OP_W-1 are
//            clamped to 2^OP_W-1 (MSB of res_sum stays 0).
//
// Revision : 1.0  initial release
// ============================================================================

module nibble_add_arbiter #(
    parameter int OP_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_a,
    input  logic [OP_W-1:0] a_op0,
    input  logic [OP_W-1:0] a_op1,
    input  logic            req_b,
    input  logic [OP_W-1:0] b_op0,
    input  logic [OP_W-1:0] b_op1,
    input  logic            res_ready,
    output logic            gnt_a,
    output logic            gnt_b,
    output logic            res_valid,
    output logic            res_id,
    output logic [OP_W:0]   res_sum,
    output logic            busy,
    output logic [7:0]      done_cnt
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    // Latched operands of the current winner
    logic [OP_W-1:0] r_op0;
    logic [OP_W-1:0] r_op1;

    // Round-robin pointer: 1 means B won last. Kept apart from r_res_id
    // because the two reset to different values.
    logic            r_last_b;
    logic            r_res_id;
    logic [OP_W:0]   r_res_sum;
    logic [7:0]      r_done_cnt;

    logic            w_latch;
    logic            w_accept;
    logic            w_win_b;
    logic [OP_W:0]   w_sum_full;
    logic [OP_W:0]   w_sum;

    // ------------------------------------------------------------------------
    // Round-robin winner
    // B wins when it is the only requester, or when both request and A was
    // the previous winner. With r_last_b = 1 after reset, A wins the first
    // simultaneous request.
    // ------------------------------------------------------------------------
    assign w_win_b = req_b & (~req_a | ~r_last_b);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic and datapath strobes
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_a || req_b) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_state_nxt = ST_OUT;
            end
            ST_OUT: begin
                // Back-pressure: remain here until the consumer takes it.
                if (res_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Shared adder; operands are zero-extended so the carry lands in the MSB
    // ------------------------------------------------------------------------
    assign w_sum_full = {1'b0, r_op0} + {1'b0, r_op1};

`ifdef NIBBLE_ADD_SAT_EN
    localparam logic [OP_W:0] c_sat_max = {1'b0, {OP_W{1'b1}}};

    // A set carry bit is exactly the "true sum above 2^OP_W-1" case.
    assign w_sum = w_sum_full[OP_W] ? c_sat_max : w_sum_full;
`else
    assign w_sum = w_sum_full;
`endif

    // ------------------------------------------------------------------------
    // Operand latch, winner bookkeeping, result and completion counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op0      <= '0;
            r_op1      <= '0;
            r_last_b   <= 1'b1;
            r_res_id   <= 1'b0;
            r_res_sum  <= '0;
            r_done_cnt <= 8'd0;
        end else begin
            if (w_latch) begin
                // Operands are captured once; later changes are ignored.
                r_op0    <= w_win_b ? b_op0 : a_op0;
                r_op1    <= w_win_b ? b_op1 : a_op1;
                r_res_id <= w_win_b;
                r_last_b <= w_win_b;
            end
            if (r_state == ST_EXEC) begin
                r_res_sum <= w_sum;
            end
            if (w_accept) begin
                r_done_cnt <= r_done_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: decoded from registered state, so they drop at once on reset
    // ------------------------------------------------------------------------
    assign gnt_a     = (r_state == ST_EXEC) & ~r_res_id;
    assign gnt_b     = (r_state == ST_EXEC) &  r_res_id;
    assign res_valid = (r_state == ST_OUT);
    assign busy      = (r_state != ST_IDLE);
    assign res_id    = r_res_id;
    assign res_sum   = r_res_sum;
    assign done_cnt  = r_done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_nibble_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_add_arbiter
// Purpose  : Directed self-checking bench for nibble_add_arbiter. A
//            transaction-level model tracks each grant by its age in cycles
//            and is compared with the DUT on every falling edge; directed
//            scenarios add hand-computed literal checks.
// Options  : honours NIBBLE_ADD_SAT_EN for the expected overflow result.
// Revision : 1.0  initial release
// ============================================================================

module tb_nibble_add_arbiter;

    localparam int OP_W = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_a;
    logic [OP_W-1:0] a_op0;
    logic [OP_W-1:0] a_op1;
    logic            req_b;
    logic [OP_W-1:0] b_op0;
    logic [OP_W-1:0] b_op1;
    logic            res_ready;
    logic            gnt_a;
    logic            gnt_b;
    logic            res_valid;
    logic            res_id;
    logic [OP_W:0]   res_sum;
    logic            busy;
    logic [7:0]      done_cnt;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    nibble_add_arbiter #(.OP_W(OP_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .a_op0     (a_op0),
        .a_op1     (a_op1),
        .req_b     (req_b),
        .b_op0     (b_op0),
        .b_op1     (b_op1),
        .res_ready (res_ready),
        .gnt_a     (gnt_a),
        .gnt_b     (gnt_b),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_sum   (res_sum),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

`ifdef NIBBLE_ADD_SAT_EN
    localparam int OVF_SUM = 15;
`else
    localparam int OVF_SUM = 30;
`endif

    // ------------------------------------------------------------------------
    // Transaction-level model: a transaction is "in flight" from its grant
    // edge until the accepting edge; age 1 is the grant cycle, age 2+ is the
    // result-held period.
    // ------------------------------------------------------------------------
    bit m_active;
    int m_age;
    bit m_id;
    bit m_last_b;
    bit m_win;
    int m_pend;
    int m_sum;
    int m_done;

    function automatic int model_add(input int x, input int y);
        int s;
        s = x + y;
`ifdef NIBBLE_ADD_SAT_EN
        if (s > (1 << OP_W) - 1) s = (1 << OP_W) - 1;
`endif
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_age    = 0;
            m_id     = 1'b0;
            m_last_b = 1'b1;
            m_pend   = 0;
            m_sum    = 0;
            m_done   = 0;
        end else if (!m_active) begin
            if (req_a || req_b) begin
                if (req_a && req_b) m_win = !m_last_b;
                else                m_win = req_b;
                m_pend   = m_win ? model_add(int'(b_op0), int'(b_op1))
                                 : model_add(int'(a_op0), int'(a_op1));
                m_id     = m_win;
                m_last_b = m_win;
                m_active = 1'b1;
                m_age    = 1;
            end
        end else if (m_age == 1) begin
            m_sum = m_pend;
            m_age = 2;
        end else if (res_ready) begin
            m_active = 1'b0;
            m_done   = (m_done + 1) % 256;
        end
    end

    // ------------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------------
    logic [17:0] exp_v;
    logic [17:0] act_v;

    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = {m_active && m_age == 1 && !m_id,
                     m_active && m_age == 1 &&  m_id,
                     m_active && m_age >= 2,
                     m_id,
                     m_active,
                     5'(m_sum),
                     8'(m_done)};
            act_v = {gnt_a, gnt_b, res_valid, res_id, busy, res_sum, done_cnt};
            vec_cnt++;
            if (act_v !== exp_v) begin
                miss_cnt++;
                $display("FAIL cycle_model t=%0t dut{ga,gb,rv,id,busy,sum,cnt}=%h model=%h",
                         $time, act_v, exp_v);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        rst_n     = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        a_op0     = '0;
        a_op1     = '0;
        b_op0     = '0;
        b_op1     = '0;
        res_ready = 1'b0;
        step();
        step();
        chk_en = 1'b1;

        // Reset state
        chk("reset_busy",     busy,      0);
        chk("reset_valid",    res_valid, 0);
        chk("reset_gnt",      {gnt_a, gnt_b}, 0);
        chk("reset_sum",      res_sum,   0);
        chk("reset_done_cnt", done_cnt,  0);
        rst_n = 1'b1;
        step();

        // Single add: A alone, 3 + 4
        req_a = 1'b1; a_op0 = 4'd3; a_op1 = 4'd4; res_ready = 1'b1;
        step();
        chk("single_gnt_a", gnt_a, 1);
        chk("single_gnt_b", gnt_b, 0);
        chk("single_id",    res_id, 0);
        req_a = 1'b0; a_op0 = 4'd9;
        step();
        chk("single_gnt_a_drop", gnt_a, 0);
        chk("single_valid",      res_valid, 1);
        chk("single_sum",        res_sum, 7);
        step();
        chk("single_valid_drop", res_valid, 0);
        chk("single_done_cnt",   done_cnt, 1);
        chk("single_busy",       busy, 0);

        // Overflow on B, then back-pressure with A waiting
        res_ready = 1'b0;
        req_b = 1'b1; b_op0 = 4'd15; b_op1 = 4'd15;
        step();
        chk("ovf_gnt_b", gnt_b, 1);
        chk("ovf_gnt_a", gnt_a, 0);
        chk("ovf_id",    res_id, 1);
        req_b = 1'b0; b_op0 = 4'd0;
        step();
        chk("ovf_valid", res_valid, 1);
        chk("ovf_sum",   res_sum, OVF_SUM);
        req_a = 1'b1; a_op0 = 4'd6; a_op1 = 4'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", res_valid, 1);
            chk("bp_sum",   res_sum, OVF_SUM);
            chk("bp_id",    res_id, 1);
            chk("bp_busy",  busy, 1);
            chk("bp_no_gnt", {gnt_a, gnt_b}, 0);
        end
        res_ready = 1'b1;
        step();
        chk("bp_idle_busy",  busy, 0);
        chk("bp_idle_valid", res_valid, 0);
        chk("bp_done_cnt",   done_cnt, 2);
        step();
        chk("waiting_a_gnt", gnt_a, 1);
        req_a = 1'b0;
        step();
        chk("waiting_a_sum", res_sum, 11);
        step();
        chk("waiting_a_done_cnt", done_cnt, 3);

        // Reset during EXEC
        req_a = 1'b1; a_op0 = 4'd1; a_op1 = 4'd1;
        step();
        chk("mid_gnt_a", gnt_a, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_gnt",   {gnt_a, gnt_b}, 0);
        chk("mid_rst_busy",  busy, 0);
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_sum",   res_sum, 0);
        chk("mid_rst_id",    res_id, 0);
        chk("mid_rst_cnt",   done_cnt, 0);
        req_a = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        req_b = 1'b1; b_op0 = 4'd5; b_op1 = 4'd6;
        step();
        chk("post_rst_gnt_b", gnt_b, 1);
        chk("post_rst_gnt_a", gnt_a, 0);
        req_b = 1'b0;
        step();
        chk("post_rst_sum", res_sum, 11);
        chk("post_rst_id",  res_id, 1);
        step();
        chk("post_rst_done_cnt", done_cnt, 1);

        // Contention: both requesting through four transactions
        req_a = 1'b1; a_op0 = 4'd1; a_op1 = 4'd2;
        req_b = 1'b1; b_op0 = 4'd8; b_op1 = 4'd9;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("rr_gnt_a", gnt_a, (k % 2 == 0) ? 1 : 0);
            chk("rr_gnt_b", gnt_b, (k % 2 == 1) ? 1 : 0);
            step();
            chk("rr_id",  res_id, k % 2);
            chk("rr_sum", res_sum, (k % 2 == 1) ? 17 : 3);
            step();
            chk("rr_idle", busy, 0);
        end
        req_a = 1'b0; req_b = 1'b0;
        chk("rr_done_cnt", done_cnt, 5);

        // Counter wrap after 256 accepted transactions
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("wrap_start_cnt", done_cnt, 0);
        req_a = 1'b1; a_op0 = 4'd0; a_op1 = 4'd0;
        for (int t = 0; t < 256; t++) begin
            step();
            a_op0 = 4'(t % 16);
            a_op1 = 4'((t * 7) % 16);
            step();
            step();
            if (t == 254) chk("wrap_cnt_255", done_cnt, 255);
            if (t == 255) chk("wrap_cnt_0",   done_cnt, 0);
        end
        req_a = 1'b0;
        step();
        step();
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule

`default_nettype wire
